// File: rtl/if_id_issue_queue_pkg.sv
// Shared widths, control-vector bit positions and pop arithmetic for the
// fetch/decode issue queue.
package if_id_issue_queue_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam int STALL_W    = 5;
    localparam int FLUSH_W    = 4;
    localparam int STALL_IFID = 1;
    localparam int FLUSH_IFID = 0;

    // Number of entries decode takes this cycle; never more than are held.
    function automatic logic [1:0] iq_pop_count(
        input logic hold,
        input logic issue_one,
        input logic has_one,
        input logic has_two
    );
        logic [1:0] n;
        if (hold || !has_one) begin
            n = 2'd0;
        end else if (issue_one || !has_two) begin
            n = 2'd1;
        end else begin
            n = 2'd2;
        end
        return n;
    endfunction

endpackage

// File: rtl/if_id_issue_queue_iq_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for the issue queue; also
// resolves the redirect/flush request into a single clear.
module iq_ptr_ctrl
    import if_id_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [1:0]       pop_n_i,
    input  logic             branch_i,
    input  logic             flush_ifid_i,
    input  logic             stall_ifid_i,
    output logic             clear_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             clear_s;

    // A held decode stage also holds off a pipeline flush; a redirect never waits.
    assign clear_s = branch_i | (flush_ifid_i & ~stall_ifid_i);

    // Next pointer/count state; clear wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_s) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_i);
            count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_n_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign clear_o  = clear_s;
    assign rd_ptr_o = rd_ptr_q;
    assign wr_ptr_o = wr_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/if_id_issue_queue.sv
// Dual-issue fetch-to-decode queue: fetch pushes one entry per cycle, decode
// sees the two oldest entries and takes zero, one or two of them.
module if_id_issue_queue
    import if_id_issue_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int INST_W = INST_WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Fetch_Valid,
    input  logic [ADDR_W-1:0]         Fetch_PC,
    input  logic [INST_W-1:0]         Fetch_Inst,
    output logic                      Fetch_Ready,
    input  logic [STALL_W-1:0]        Ctrl_Stall,
    input  logic [FLUSH_W-1:0]        Flush,
    input  logic                      issue_select,
    input  logic                      EX_BranchFlag,
    output logic                      Id_Valid_0,
    output logic [ADDR_W-1:0]         Id_PC_0,
    output logic [INST_W-1:0]         Id_Inst_0,
    output logic                      Id_Valid_1,
    output logic [ADDR_W-1:0]         Id_PC_1,
    output logic [INST_W-1:0]         Id_Inst_1,
    output logic [$clog2(DEPTH):0]    Queue_Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_s, wr_ptr_s, rd_ptr_nx_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s, clear_s, push_s;
    logic             has_one_s, has_two_s;
    logic [1:0]       pop_n_s;
    logic             unused_ctrl_s;

    assign unused_ctrl_s = ^{Ctrl_Stall, Flush};

    // Ready depends only on occupancy so fetch never waits on decode timing.
    assign Fetch_Ready = ~full_s;
    assign push_s      = Fetch_Valid & ~full_s;
    assign has_one_s   = (count_s >= CNT_W'(1));
    assign has_two_s   = (count_s >= CNT_W'(2));
    assign pop_n_s     = iq_pop_count(Ctrl_Stall[STALL_IFID], issue_select,
                                      has_one_s, has_two_s);

    iq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .pop_n_i      (pop_n_s),
        .branch_i     (EX_BranchFlag),
        .flush_ifid_i (Flush[FLUSH_IFID]),
        .stall_ifid_i (Ctrl_Stall[STALL_IFID]),
        .clear_o      (clear_s),
        .rd_ptr_o     (rd_ptr_s),
        .wr_ptr_o     (wr_ptr_s),
        .count_o      (count_s),
        .full_o       (full_s)
    );

    // Entry storage; a push coinciding with a clear is discarded.
    always_ff @(posedge clk) begin
        if (!rst && push_s && !clear_s) begin
            pc_mem_q[wr_ptr_s]   <= Fetch_PC;
            inst_mem_q[wr_ptr_s] <= Fetch_Inst;
        end
    end

    assign rd_ptr_nx_s = rd_ptr_s + PTR_W'(1);

    // Slot views of the two oldest entries; empty slots read as zero.
    always_comb begin
        Id_Valid_0 = has_one_s;
        Id_Valid_1 = has_two_s;
        Id_PC_0    = {ADDR_W{1'b0}};
        Id_Inst_0  = {INST_W{1'b0}};
        Id_PC_1    = {ADDR_W{1'b0}};
        Id_Inst_1  = {INST_W{1'b0}};
        if (has_one_s) begin
            Id_PC_0   = pc_mem_q[rd_ptr_s];
            Id_Inst_0 = inst_mem_q[rd_ptr_s];
        end else begin
            Id_PC_0   = {ADDR_W{1'b0}};
            Id_Inst_0 = {INST_W{1'b0}};
        end
        if (has_two_s) begin
            Id_PC_1   = pc_mem_q[rd_ptr_nx_s];
            Id_Inst_1 = inst_mem_q[rd_ptr_nx_s];
        end else begin
            Id_PC_1   = {ADDR_W{1'b0}};
            Id_Inst_1 = {INST_W{1'b0}};
        end
    end

    assign Queue_Count = count_s;

endmodule

// File: tb/tb_if_id_issue_queue.sv
// Directed and model-checked stimulus for the fetch/decode issue queue.
module tb_if_id_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        Fetch_Valid;
    logic [31:0] Fetch_PC;
    logic [31:0] Fetch_Inst;
    logic        Fetch_Ready;
    logic [4:0]  Ctrl_Stall;
    logic [3:0]  Flush;
    logic        issue_select;
    logic        EX_BranchFlag;
    logic        Id_Valid_0, Id_Valid_1;
    logic [31:0] Id_PC_0, Id_PC_1, Id_Inst_0, Id_Inst_1;
    logic [2:0]  Queue_Count;

    int checks = 0;
    int errors = 0;
    logic [31:0] mq[$];
    logic [31:0] pc_gen;

    if_id_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .Fetch_Valid(Fetch_Valid), .Fetch_PC(Fetch_PC), .Fetch_Inst(Fetch_Inst),
        .Fetch_Ready(Fetch_Ready), .Ctrl_Stall(Ctrl_Stall), .Flush(Flush),
        .issue_select(issue_select), .EX_BranchFlag(EX_BranchFlag),
        .Id_Valid_0(Id_Valid_0), .Id_PC_0(Id_PC_0), .Id_Inst_0(Id_Inst_0),
        .Id_Valid_1(Id_Valid_1), .Id_PC_1(Id_PC_1), .Id_Inst_1(Id_Inst_1),
        .Queue_Count(Queue_Count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [4:0] st,
                         input logic [3:0] fl, input logic is, input logic br);
        Fetch_Valid   = fv;
        Fetch_PC      = pc;
        Fetch_Inst    = inst_of(pc);
        Ctrl_Stall    = st;
        Flush         = fl;
        issue_select  = is;
        EX_BranchFlag = br;
    endtask

    task automatic slots(input string tag, input logic [2:0] cnt,
                         input logic v0, input logic [31:0] p0,
                         input logic v1, input logic [31:0] p1);
        chk({tag, "_cnt"}, 32'(Queue_Count), 32'(cnt));
        chk({tag, "_v0"},  32'(Id_Valid_0), 32'(v0));
        chk({tag, "_pc0"}, Id_PC_0, p0);
        chk({tag, "_in0"}, Id_Inst_0, v0 ? inst_of(p0) : 32'h0);
        chk({tag, "_v1"},  32'(Id_Valid_1), 32'(v1));
        chk({tag, "_pc1"}, Id_PC_1, p1);
        chk({tag, "_in1"}, Id_Inst_1, v1 ? inst_of(p1) : 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        slots("reset", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("reset_ready", 32'(Fetch_Ready), 32'd1);

        // Fill A,B,C with decode held
        drive(1'b1, 32'h100, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        slots("pushA", 3'd1, 1'b1, 32'h100, 1'b0, 32'h0);
        drive(1'b1, 32'h104, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        slots("pushB", 3'd2, 1'b1, 32'h100, 1'b1, 32'h104);
        drive(1'b1, 32'h108, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        slots("pushC", 3'd3, 1'b1, 32'h100, 1'b1, 32'h104);

        // Single issue: slot 1 moves up to slot 0
        drive(1'b0, 32'h0, 5'b00000, 4'b0000, 1'b1, 1'b0); tick();
        slots("iss1", 3'd2, 1'b1, 32'h104, 1'b1, 32'h108);
        tick();
        slots("iss1b", 3'd1, 1'b1, 32'h108, 1'b0, 32'h0);

        // Stall and fill to full across pointer wrap
        drive(1'b1, 32'h10C, 5'b00011, 4'b0000, 1'b0, 1'b0); tick();
        slots("fillD", 3'd2, 1'b1, 32'h108, 1'b1, 32'h10C);
        drive(1'b1, 32'h110, 5'b00011, 4'b0000, 1'b0, 1'b0); tick();
        slots("fillE", 3'd3, 1'b1, 32'h108, 1'b1, 32'h10C);
        drive(1'b1, 32'h114, 5'b00011, 4'b0000, 1'b0, 1'b0); tick();
        slots("fillF", 3'd4, 1'b1, 32'h108, 1'b1, 32'h10C);
        chk("full_ready", 32'(Fetch_Ready), 32'd0);
        drive(1'b1, 32'h118, 5'b00011, 4'b0000, 1'b0, 1'b0); tick();
        slots("fullhold", 3'd4, 1'b1, 32'h108, 1'b1, 32'h10C);

        // Full with a pop: the offered push is still refused
        drive(1'b1, 32'h11C, 5'b00000, 4'b0000, 1'b1, 1'b0); tick();
        slots("fullpop", 3'd3, 1'b1, 32'h10C, 1'b1, 32'h110);
        chk("fullpop_ready", 32'(Fetch_Ready), 32'd1);
        drive(1'b1, 32'h118, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        slots("refill", 3'd4, 1'b1, 32'h10C, 1'b1, 32'h110);

        // Redirect with fetch valid, full and then empty
        drive(1'b1, 32'h200, 5'b00010, 4'b0000, 1'b0, 1'b1); tick();
        slots("brfull", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("br_ready", 32'(Fetch_Ready), 32'd1);
        drive(1'b1, 32'h204, 5'b00000, 4'b0000, 1'b0, 1'b1); tick();
        slots("brpush", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Empty + push + pop request: no bypass
        drive(1'b1, 32'h180, 5'b00000, 4'b0000, 1'b0, 1'b0); tick();
        slots("nobyp", 3'd1, 1'b1, 32'h180, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 5'b00000, 4'b0000, 1'b0, 1'b0); tick();
        slots("drain", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        // IF/ID flush honoured only when decode is not held
        drive(1'b1, 32'h300, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h304, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,   5'b00000, 4'b0001, 1'b0, 1'b0); tick();
        slots("flush", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h308, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h30C, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,   5'b00010, 4'b0001, 1'b0, 1'b0); tick();
        slots("flushheld", 3'd2, 1'b1, 32'h308, 1'b1, 32'h30C);

        // Reset mid-operation overrides a push
        rst = 1'b1;
        drive(1'b1, 32'h400, 5'b00010, 4'b0000, 1'b0, 1'b0); tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        slots("midrst", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Random traffic against a reference queue
        mq.delete();
        pc_gen = 32'h1000;
        for (int i = 0; i < 64; i++) begin
            logic fv, hold, is, br, rdy;
            int pop;
            fv   = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 2) == 0);
            is   = $urandom_range(0, 1) == 1;
            br   = ($urandom_range(0, 15) == 0);
            drive(fv, pc_gen, {3'b000, hold, 1'b0}, 4'b0000, is, br);
            rdy = (mq.size() != 4);
            chk("rnd_ready", 32'(Fetch_Ready), 32'(rdy));
            pop = hold ? 0 : ((is ? 1 : 2) < mq.size() ? (is ? 1 : 2) : mq.size());
            tick();
            if (br) begin
                mq.delete();
            end else begin
                for (int k = 0; k < pop; k++) void'(mq.pop_front());
                if (fv && rdy) mq.push_back(pc_gen);
            end
            if (fv && rdy) pc_gen = pc_gen + 32'd4;
            slots("rnd", 3'(mq.size()),
                  mq.size() >= 1, (mq.size() >= 1) ? mq[0] : 32'h0,
                  mq.size() >= 2, (mq.size() >= 2) ? mq[1] : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
